fir_fifo_scheduler: RTL and testbench

- Round-robin scheduler that shares one FIR MAC engine between NUM_CH sample FIFOs, each 16-bit with show-ahead read data.
- Per grant: picks an eligible channel, pops one sample, hands the sample and channel id to the MAC with a valid/ready handshake, then waits for the MAC's done pulse.
- Sits between the per-channel input FIFOs and the shared filter datapath in the FIR top level.

---
 rtl/fir_fifo_scheduler.sv | 135 +++++++++++++
 tb/tb_fir_fifo_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_fifo_scheduler.sv
// Round-robin scheduler sharing one FIR MAC engine between NUM_CH show-ahead sample FIFOs.
// One grant = pop one sample, hand it to the MAC over valid/ready, then wait for mac_done.
module fir_fifo_scheduler #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         fifo_empty,
  input  logic [NUM_CH*DATA_W-1:0]  fifo_rd_data,
  output logic [NUM_CH-1:0]         fifo_rd_en,
  output logic                      mac_start,
  input  logic                      mac_ready,
  output logic [$clog2(NUM_CH)-1:0] mac_ch,
  output logic [DATA_W-1:0]         mac_sample,
  input  logic                      mac_done,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPop, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     grant_q, grant_d;
  logic [CH_W-1:0]     last_q, last_d;
  logic [CH_W-1:0]     mac_ch_q, mac_ch_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic                terr_q, terr_d;
  logic [NUM_CH-1:0]   elig;
  logic                found;
  logic [CH_W-1:0]     next_ch;

  assign elig = ch_enable & ~fifo_empty;

  // First eligible channel searching from last_q+1 with wrap.
  always_comb begin
    int unsigned     idx;
    logic [CH_W-1:0] idx_c;
    found   = 1'b0;
    next_ch = '0;
    idx     = 0;
    idx_c   = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx   = (32'(last_q) + k) % NUM_CH;
      idx_c = CH_W'(idx);
      if (!found && elig[idx_c]) begin
        found   = 1'b1;
        next_ch = idx_c;
      end
    end
  end

  // Saturating wait counter increment.
  assign cnt_inc = (cnt_q == CNT_W'(DONE_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    mac_ch_d   = mac_ch_q;
    sample_d   = sample_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    fifo_rd_en = '0;
    case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = next_ch;
          state_d = StPop;
        end
      end
      StPop: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (grant_q == CH_W'(i)) begin
            fifo_rd_en[i] = 1'b1;
            sample_d      = fifo_rd_data[i*DATA_W +: DATA_W];
          end
        end
        mac_ch_d = grant_q;
        state_d  = StIssue;
      end
      StIssue: begin
        if (mac_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (mac_done) begin
          last_d  = grant_q;
          state_d = StIdle;
        end else if (cnt_inc == CNT_W'(DONE_TIMEOUT)) begin
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= CH_W'(NUM_CH - 1);
      mac_ch_q <= '0;
      sample_q <= '0;
      cnt_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      mac_ch_q <= mac_ch_d;
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      terr_q   <= terr_d;
    end
  end

  assign mac_start   = (state_q == StIssue);
  assign busy        = (state_q != StIdle);
  assign mac_ch      = mac_ch_q;
  assign mac_sample  = sample_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fir_fifo_scheduler.sv
// Bench for fir_fifo_scheduler: queue-based FIFO and MAC models, a per-cycle reference
// model of the grant sequence, directed boundary cases and a randomized soak.
module tb_fir_fifo_scheduler;
  localparam int NUM_CH       = 4;
  localparam int DATA_W       = 16;
  localparam int DONE_TIMEOUT = 255;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_enable = '0;
  logic [NUM_CH-1:0]        fifo_empty = '1;
  logic [NUM_CH*DATA_W-1:0] fifo_rd_data = '0;
  logic [NUM_CH-1:0]        fifo_rd_en;
  logic                     mac_start;
  logic                     mac_ready = 1'b0;
  logic [1:0]               mac_ch;
  logic [DATA_W-1:0]        mac_sample;
  logic                     mac_done = 1'b0;
  logic                     busy;
  logic                     timeout_err;

  always #5 clk = ~clk;

  fir_fifo_scheduler #(
    .NUM_CH      (NUM_CH),
    .DATA_W      (DATA_W),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_enable   (ch_enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .mac_start   (mac_start),
    .mac_ready   (mac_ready),
    .mac_ch      (mac_ch),
    .mac_sample  (mac_sample),
    .mac_done    (mac_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] fq[NUM_CH][$];
  int grants[$];
  int ready_mode = 1;  // 0 random, 1 high, 2 low
  int done_mode  = 1;  // 0 random, 1 never, 2 one cycle after accept, 3 driven by main
  int mcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_rd_data[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic push(input int ch, input logic [DATA_W-1:0] v);
    fq[ch].push_back(v);
    refresh();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_CH; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Advance one cycle: apply the pop seen this cycle, then drive next-cycle inputs at +1.
  task automatic tick();
    logic [NUM_CH-1:0] pop;
    logic              acc;
    pop = fifo_rd_en;
    acc = mac_start && mac_ready;
    @(posedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      if (pop[i]) begin
        if (fq[i].size() > 0) fq[i].delete(0);
        grants.push_back(i);
      end
    end
    #1;
    refresh();
    mcyc++;
    case (ready_mode)
      0:       mac_ready = ($urandom_range(9) < 6);
      1:       mac_ready = 1'b1;
      default: mac_ready = 1'b0;
    endcase
    case (done_mode)
      0:       mac_done = ($urandom_range(5) == 0);
      1:       mac_done = 1'b0;
      2:       mac_done = acc;
      default: ;
    endcase
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((!all_empty() || busy) && n < 2000) begin
      tick();
      n++;
    end
    chk(nm, (n < 2000), 1);
  endtask

  task automatic wait_accept(input string nm, output int a);
    int n = 0;
    while (!(mac_start && mac_ready) && n < 20) begin
      tick();
      n++;
    end
    chk(nm, (n < 20), 1);
    a = mcyc;
  endtask

  // Reference model: which transaction step each cycle belongs to and what it must show.
  int                ph = 0;  // 0 idle, 1 pop, 2 presenting, 3 awaiting done
  int                mg = 0;
  int                mlast = NUM_CH - 1;
  int                mwait = 0;
  int                mch = 0;
  logic              mterr = 1'b0;
  logic [DATA_W-1:0] msamp = '0;

  always @(negedge clk) begin
    logic [NUM_CH-1:0] e;
    bit                picked;
    if (!rst) begin
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_mac_start", mac_start, 0);
      chk("rst_mac_ch", mac_ch, 0);
      chk("rst_mac_sample", mac_sample, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      ph = 0; mg = 0; mlast = NUM_CH - 1; mch = 0; msamp = '0; mterr = 1'b0; mwait = 0;
    end else begin
      chk("busy", busy, (ph != 0));
      chk("rd_en", fifo_rd_en, (ph == 1) ? (1 << mg) : 0);
      chk("mac_start", mac_start, (ph == 2));
      chk("mac_ch", mac_ch, mch);
      chk("mac_sample", mac_sample, msamp);
      chk("timeout_err", timeout_err, mterr);
      case (ph)
        0: begin
          for (int i = 0; i < NUM_CH; i++) e[i] = ch_enable[i] && (fq[i].size() > 0);
          picked = 1'b0;
          for (int k = 1; k <= NUM_CH; k++) begin
            if (!picked && e[(mlast + k) % NUM_CH]) begin
              picked = 1'b1;
              mg = (mlast + k) % NUM_CH;
            end
          end
          if (picked) ph = 1;
        end
        1: begin
          chk("model_head", (fq[mg].size() > 0), 1);
          if (fq[mg].size() > 0) msamp = fq[mg][0];
          mch = mg;
          ph = 2;
        end
        2: if (mac_ready) begin ph = 3; mwait = 0; end
        default: begin
          mwait++;
          if (mac_done) begin
            mlast = mg; ph = 0;
          end else if (mwait == DONE_TIMEOUT) begin
            mterr = 1'b1; mlast = mg; ph = 0;
          end
        end
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, e, n, cnt2;
    logic [DATA_W-1:0] held;
    #1 rst = 1'b0;

    // Reset held with every channel eligible: no pops, then first grant is channel 0.
    ch_enable = '1;
    for (int i = 0; i < NUM_CH; i++) push(i, 16'h1000 + 16'(i));
    grants.delete();
    repeat (3) tick();
    chk("rst_no_pop", grants.size(), 0);
    chk("rst_hold_busy", busy, 0);
    rst = 1'b1;
    done_mode = 2;
    n = 0;
    while (grants.size() == 0 && n < 20) begin tick(); n++; end
    chk("first_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    drain("drain_after_reset");

    // Single channel latency.
    push(2, 16'h1234);
    tick();
    chk("single_rd_en", fifo_rd_en, 4'b0100);
    tick();
    chk("single_start", mac_start, 1);
    chk("single_ch", mac_ch, 2);
    chk("single_sample", mac_sample, 16'h1234);
    tick();
    chk("single_wait_busy", busy, 1);
    tick();
    chk("single_idle", busy, 0);

    // Round robin over all channels, three words each.
    reset_pulse();
    grants.delete();
    for (int w = 0; w < 3; w++) for (int i = 0; i < NUM_CH; i++) push(i, 16'($urandom));
    drain("rr_drain");
    chk("rr_len", grants.size(), 12);
    for (int k = 0; k < 12; k++) chk("rr_order", (k < grants.size()) ? grants[k] : -1, k % NUM_CH);
    chk("rr_idle", busy, 0);

    // Backpressure: sample held 10 cycles, transfer the cycle ready rises.
    ready_mode = 2;
    grants.delete();
    push(0, 16'hBEEF);
    n = 0;
    while (!mac_start && n < 10) begin tick(); n++; end
    chk("bp_reach_issue", mac_start, 1);
    held = mac_sample;
    chk("bp_sample", held, 16'hBEEF);
    repeat (10) begin
      tick();
      chk("bp_held", mac_start, 1);
      chk("bp_stable", mac_sample, 16'hBEEF);
    end
    chk("bp_pops", grants.size(), 1);
    mac_ready = 1'b1;
    ready_mode = 1;
    tick();
    chk("bp_released", mac_start, 0);
    chk("bp_waiting", busy, 1);
    drain("bp_drain");

    // Disabled channel skipped: last grant 1, channel 2 disabled.
    push(1, 16'h0101);
    drain("skip_prep");
    ch_enable = 4'b1011;
    grants.delete();
    for (int i = 0; i < NUM_CH; i++) push(i, 16'h2000 + 16'(i));
    n = 0;
    while ((busy || fq[0].size() + fq[1].size() + fq[3].size() != 0) && n < 200) begin
      tick(); n++;
    end
    chk("skip_first", (grants.size() > 0) ? grants[0] : -1, 3);
    cnt2 = 0;
    foreach (grants[k]) if (grants[k] == 2) cnt2++;
    chk("skip_never2", cnt2, 0);
    chk("skip_len", grants.size(), 3);
    ch_enable = '1;
    drain("skip_drain");

    // Timeout: no done ever; error raised DONE_TIMEOUT edges after the accept edge.
    reset_pulse();
    done_mode = 1;
    push(0, 16'h00AA);
    push(1, 16'h00BB);
    wait_accept("to_accept", a);
    n = 0;
    while (!timeout_err && n < 400) begin tick(); n++; end
    e = mcyc;
    // The accept edge closes cycle a, so the error first shows in cycle a+1+DONE_TIMEOUT.
    chk("to_latency", e - a - 1, DONE_TIMEOUT);
    chk("to_idle", busy, 0);
    tick();
    chk("to_next_grant", fifo_rd_en, 4'b0010);
    done_mode = 2;
    drain("to_drain");
    chk("to_sticky", timeout_err, 1);

    // Done on the final count cycle wins over the timeout.
    reset_pulse();
    chk("to_cleared", timeout_err, 0);
    done_mode = 3;
    mac_done = 1'b0;
    push(2, 16'h00CC);
    wait_accept("fd_accept", a);
    repeat (DONE_TIMEOUT - 1) tick();
    tick();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    chk("fd_no_err", timeout_err, 0);
    chk("fd_idle", busy, 0);

    // Randomized soak with mid-operation resets.
    done_mode = 0;
    ready_mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(49) == 0) ch_enable = 4'($urandom);
      if ($urandom_range(2) == 0) begin
        int ch = $urandom_range(NUM_CH - 1);
        if (fq[ch].size() < 4) push(ch, 16'($urandom));
      end
      if ($urandom_range(499) == 0) rst = 1'b0;
      else rst = 1'b1;
      tick();
    end
    rst = 1'b1;
    ch_enable = '1;
    ready_mode = 1;
    done_mode = 2;
    drain("soak_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
